// File: rtl/seg7_scan_if.sv
// seg7_scan_if: scan strobe, display data in, and digit/segment drive out.
// master = data source side, slave = display driver.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic                  tick;
  logic                  en;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output tick, en, data, dp_in, blank,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  tick, en, data, dp_in, blank,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 7-seg driver, one digit per scan tick.
// Data is frozen per frame at digit 0 so a refresh never tears.
module seg7_scan #(
  parameter int DIGITS     = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int            IW   = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic          OFF  = ACTIVE_LOW;

  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [4*DIGITS-1:0] src_data;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_blank;
  logic [3:0]          nib;
  logic                on;
  logic [6:0]          hex;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   an_q;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_q;
  logic [6:0]          seg_nxt;
  logic                dp_q;
  logic                dp_nxt;
  logic                fd_q;

  always_comb begin
    idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;
  end

  // Digit 0 reads live inputs: it is the frame being captured now
  always_comb begin
    src_data  = sh_data;
    src_dp    = sh_dp;
    src_blank = sh_blank;
    if (idx == '0) begin
      src_data  = bus.data;
      src_dp    = bus.dp_in;
      src_blank = bus.blank;
    end
    nib = src_data[{idx, 2'b00} +: 4];
    on  = bus.en & ~src_blank[idx];
  end

  always_comb begin
    hex = 7'h00;
    unique case (nib)
      4'h0: hex = 7'h3F;
      4'h1: hex = 7'h06;
      4'h2: hex = 7'h5B;
      4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;
      4'h5: hex = 7'h6D;
      4'h6: hex = 7'h7D;
      4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h6F;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;
      4'hD: hex = 7'h5E;
      4'hE: hex = 7'h79;
      4'hF: hex = 7'h71;
    endcase
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    an_nxt      = {DIGITS{OFF}};
    seg_nxt     = {7{OFF}};
    dp_nxt      = OFF;
    if (on) begin
      an_nxt  = onehot ^ {DIGITS{OFF}};
      seg_nxt = hex ^ {7{OFF}};
      dp_nxt  = src_dp[idx] ^ OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      an_q     <= {DIGITS{OFF}};
      seg_q    <= {7{OFF}};
      dp_q     <= OFF;
      fd_q     <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (bus.tick) begin
        idx   <= idx_nxt;
        an_q  <= an_nxt;
        seg_q <= seg_nxt;
        dp_q  <= dp_nxt;
        fd_q  <= (idx == LAST);
        if (idx == '0) begin
          sh_data  <= bus.data;
          sh_dp    <= bus.dp_in;
          sh_blank <= bus.blank;
        end
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of scan order, decode, snapshot,
// blanking, reset and a 5-digit active-high build.
module tb_seg7_scan;
  logic clk = 1'b0;
  logic rst;
  logic rst5;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(8)) b8 ();
  seg7_scan_if #(.DIGITS(5)) b5 ();

  seg7_scan #(.DIGITS(8), .ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  seg7_scan #(.DIGITS(5), .ACTIVE_LOW(1'b0)) dut5 (
    .clk (clk),
    .rst (rst5),
    .bus (b5)
  );

  // active-high gfedcba patterns
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic pulse();
    b8.tick = 1'b1;
    @(posedge clk); #1;
    b8.tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_chk++;
    if (b8.an !== 8'hFF) begin
      n_err++; $display("FAIL reset_an got %h want FF", b8.an);
    end
    n_chk++;
    if (b8.seg !== 7'h7F) begin
      n_err++; $display("FAIL reset_seg got %h want 7F", b8.seg);
    end
    n_chk++;
    if (b8.dp !== 1'b1 || b8.frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dp_fd got %b%b want 10",
               b8.dp, b8.frame_done);
    end
  endtask

  task automatic test_first_frame();
    pulse();
    n_chk++;
    if (b8.an !== 8'hFE || b8.seg !== 7'h21) begin
      n_err++;
      $display("FAIL tick1 got an=%h seg=%h want FE/21", b8.an, b8.seg);
    end
    for (int i = 2; i <= 7; i++) pulse();
    pulse();
    n_chk++;
    if (b8.an !== 8'h7F || b8.seg !== 7'h79 || b8.frame_done !== 1'b1)
    begin
      n_err++;
      $display("FAIL tick8 got an=%h seg=%h fd=%b want 7F/79/1",
               b8.an, b8.seg, b8.frame_done);
    end
    @(posedge clk); #1;
    n_chk++;
    if (b8.frame_done !== 1'b0 || b8.an !== 8'h7F) begin
      n_err++;
      $display("FAIL fd_one_cycle got fd=%b an=%h want 0/7F",
               b8.frame_done, b8.an);
    end
  endtask

  task automatic test_scan_wrap();
    logic [31:0] d;
    logic [7:0]  ea;
    logic [6:0]  es;
    d = 32'h1234_ABCD;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pulse();
      ea = ~(8'd1 << (i % 8));
      es = ~hex7(d[4*(i%8) +: 4]);
      n_chk++;
      if (b8.an !== ea || b8.seg !== es) begin
        n_err++;
        $display("FAIL wrap_an_seg tick%0d got %h/%h want %h/%h",
                 i + 1, b8.an, b8.seg, ea, es);
      end
      n_chk++;
      if (b8.frame_done !== ((i % 8) == 7)) begin
        n_err++;
        $display("FAIL wrap_fd tick%0d got %b", i + 1, b8.frame_done);
      end
      n_chk++;
      if (dut.idx > 3'd7) begin
        n_err++; $display("FAIL wrap_idx got %0d want <=7", dut.idx);
      end
      repeat (4) begin
        @(posedge clk); #1;
      end
      n_chk++;
      if (b8.frame_done !== 1'b0 || b8.an !== ea) begin
        n_err++;
        $display("FAIL wrap_hold tick%0d got fd=%b an=%h want 0/%h",
                 i + 1, b8.frame_done, b8.an, ea);
      end
    end
  endtask

  task automatic test_tearing();
    logic [6:0] exp_seg [6];
    exp_seg = '{7'h08, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    do_reset();
    repeat (3) pulse();
    b8.data = 32'h0000_0000;
    for (int i = 0; i < 6; i++) begin
      pulse();
      n_chk++;
      if (b8.seg !== exp_seg[i]) begin
        n_err++;
        $display("FAIL tear tick%0d got seg=%h want %h",
                 i + 4, b8.seg, exp_seg[i]);
      end
    end
    b8.data = 32'h1234_ABCD;
  endtask

  task automatic test_blank_dp();
    do_reset();
    b8.blank = 8'h02;
    b8.dp_in = 8'h01;
    pulse();
    n_chk++;
    if (b8.dp !== 1'b0 || b8.an !== 8'hFE || b8.seg !== 7'h21) begin
      n_err++;
      $display("FAIL dp_digit0 got dp=%b an=%h seg=%h want 0/FE/21",
               b8.dp, b8.an, b8.seg);
    end
    pulse();
    n_chk++;
    if (b8.an !== 8'hFF || b8.seg !== 7'h7F || b8.dp !== 1'b1) begin
      n_err++;
      $display("FAIL blank_digit1 got an=%h seg=%h dp=%b want FF/7F/1",
               b8.an, b8.seg, b8.dp);
    end
    pulse();
    n_chk++;
    if (b8.an !== 8'hFB || b8.seg !== 7'h03 || b8.dp !== 1'b1) begin
      n_err++;
      $display("FAIL digit2 got an=%h seg=%h dp=%b want FB/03/1",
               b8.an, b8.seg, b8.dp);
    end
    pulse();
    b8.en = 1'b0;
    for (int k = 4; k < 8; k++) begin
      pulse();
      n_chk++;
      if (b8.an !== 8'hFF || b8.seg !== 7'h7F || b8.dp !== 1'b1 ||
          b8.frame_done !== (k == 7)) begin
        n_err++;
        $display("FAIL en_off digit%0d got an=%h seg=%h dp=%b fd=%b",
                 k, b8.an, b8.seg, b8.dp, b8.frame_done);
      end
    end
    b8.en    = 1'b1;
    b8.blank = 8'h00;
    b8.dp_in = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) pulse();
    do_reset();
    n_chk++;
    if (b8.an !== 8'hFF || b8.frame_done !== 1'b0 || b8.seg !== 7'h7F)
    begin
      n_err++;
      $display("FAIL mid_reset got an=%h fd=%b seg=%h want FF/0/7F",
               b8.an, b8.frame_done, b8.seg);
    end
    b8.data = 32'h1234_ABC7;
    pulse();
    n_chk++;
    if (b8.an !== 8'hFE || b8.seg !== 7'h78) begin
      n_err++;
      $display("FAIL post_reset_tick got an=%h seg=%h want FE/78",
               b8.an, b8.seg);
    end
    pulse();
    n_chk++;
    if (b8.an !== 8'hFD || b8.seg !== 7'h46) begin
      n_err++;
      $display("FAIL post_reset_shadow got an=%h seg=%h want FD/46",
               b8.an, b8.seg);
    end
  endtask

  task automatic test_param5();
    logic [6:0] es [5];
    logic [4:0] ea;
    es = '{7'h3F, 7'h06, 7'h7F, 7'h4F, 7'h66};
    rst5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst5 = 1'b0;
    n_chk++;
    if (b5.an !== 5'h00 || b5.seg !== 7'h00 || b5.dp !== 1'b0) begin
      n_err++;
      $display("FAIL p5_reset got an=%h seg=%h dp=%b want 00/00/0",
               b5.an, b5.seg, b5.dp);
    end
    b5.tick = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      ea = 5'd1 << (c % 5);
      n_chk++;
      if (b5.an !== ea || b5.seg !== es[c % 5] ||
          b5.frame_done !== ((c % 5) == 4)) begin
        n_err++;
        $display("FAIL p5 cyc%0d got an=%h seg=%h fd=%b want %h/%h/%b",
                 c, b5.an, b5.seg, b5.frame_done, ea, es[c % 5],
                 (c % 5) == 4);
      end
    end
    b5.tick = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rst5     = 1'b1;
    b8.tick  = 1'b0;
    b8.en    = 1'b1;
    b8.data  = 32'h1234_ABCD;
    b8.dp_in = 8'h00;
    b8.blank = 8'h00;
    b5.tick  = 1'b0;
    b5.en    = 1'b1;
    b5.data  = 20'h4_3_8_1_0;
    b5.dp_in = 5'h00;
    b5.blank = 5'h00;
    @(posedge clk); #1;
    test_reset();
    test_first_frame();
    test_scan_wrap();
    test_tearing();
    test_blank_dp();
    test_reset_mid();
    test_param5();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
